// File: rtl/slice_symbols.sv
// Symbol slicer: accepts DW-bit words over valid/ack and emits them LSB-first
// as 1-, 2- or 4-bit symbols, one per symbol strobe, with no gap between words.
module slice_symbols #(
    parameter int DW   = 32,
    parameter int MAXB = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      mode_i,
    input  logic            sym_en_i,
    input  logic            valid_i,
    input  logic [DW-1:0]   data_i,
    output logic            ack_i,
    output logic            valid_o,
    output logic [MAXB-1:0] data_o,
    output logic            last_o,
    output logic            busy_o
);

    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b01,
        S_ACTIVE = 2'b10
    } state_t;

    state_t          r_state, w_state_nx;
    logic [DW-1:0]   r_shift, w_shift_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [2:0]      r_bps, w_bps_nx;
    logic            r_ack, w_ack_nx;
    logic            r_valid, w_valid_nx;
    logic            r_last, w_last_nx;
    logic [MAXB-1:0] r_data, w_data_nx;
    logic [MAXB-1:0] w_sym;
    logic [CW-1:0]   w_last_idx;
    logic            w_at_last;

    function automatic logic [2:0] decode_bps(input logic [1:0] mode);
        case (mode)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Index of the final symbol and the current symbol, both for the latched bps
    always_comb begin
        case (r_bps)
            3'd2: begin
                w_last_idx = CW'(DW / 2 - 1);
                w_sym      = MAXB'(r_shift[1:0]);
            end
            3'd4: begin
                w_last_idx = CW'(DW / 4 - 1);
                w_sym      = MAXB'(r_shift[3:0]);
            end
            default: begin
                w_last_idx = CW'(DW - 1);
                w_sym      = MAXB'(r_shift[0]);
            end
        endcase
    end

    assign w_at_last = (r_cnt == w_last_idx);

    // Next-state and next-output logic
    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_cnt_nx   = r_cnt;
        w_bps_nx   = r_bps;
        w_ack_nx   = 1'b0;
        w_valid_nx = 1'b0;
        w_last_nx  = 1'b0;
        w_data_nx  = r_data;
        case (r_state)
            S_IDLE: begin
                if (valid_i) begin
                    w_shift_nx = data_i;
                    w_bps_nx   = decode_bps(mode_i);
                    w_cnt_nx   = {CW{1'b0}};
                    w_ack_nx   = 1'b1;
                    w_state_nx = S_ACTIVE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (sym_en_i) begin
                    w_data_nx  = w_sym;
                    w_valid_nx = 1'b1;
                    w_last_nx  = w_at_last;
                    if (!w_at_last) begin
                        w_shift_nx = r_shift >> r_bps;
                        w_cnt_nx   = r_cnt + CW'(1);
                    end else if (valid_i) begin
                        // Back-to-back: reload on the final strobe so the next word has no gap
                        w_shift_nx = data_i;
                        w_bps_nx   = decode_bps(mode_i);
                        w_cnt_nx   = {CW{1'b0}};
                        w_ack_nx   = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_shift_nx = r_shift;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_shift <= {DW{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_bps   <= 3'd1;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= {MAXB{1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_cnt   <= w_cnt_nx;
            r_bps   <= w_bps_nx;
            r_ack   <= w_ack_nx;
            r_valid <= w_valid_nx;
            r_last  <= w_last_nx;
            r_data  <= w_data_nx;
        end
    end

    assign ack_i   = r_ack;
    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign last_o  = r_last;
    assign busy_o  = (r_state == S_ACTIVE);

endmodule
